hwag_vr_capture: RTL
====================

// Module: hwag_vr_capture
// PURPOSE
//   Upstream front end of the hwag angle generator: conditions the raw crank VR comparator input.
//   Filters it, detects tooth edges and measures the tooth period in clk cycles.
//   Finds the missing-tooth gap and tracks crank-wheel synchronisation.
//   Feeds hwag with a filtered signal, per-tooth strobes, the period, the tooth index and sync status.
// PARAMETERS
//   PCNT_W   24  tooth-period counter width (cycles); saturates at all-ones
//   FILT_W   16  width of the filter-length config value
//   TEETH    60  wheel tooth positions per revolution, including missing ones
//   MISSING  2   number of missing teeth (the gap)
//   CNT_W    6   tooth index width, >= clog2(TEETH)
// PORTS
//   clk          in   1       single system clock
//   rst          in   1       reset; synchronous, active-high
//   vr_in        in   1       raw VR comparator output, asynchronous
//   filt_len     in   FILT_W  filter length in clk cycles; 0 treated as 1
//   vr_filt      out  1       filtered and synchronised VR level
//   tooth_stb    out  1       one-cycle pulse per accepted tooth edge
//   tooth_period out  PCNT_W  cycles between the last two edges; valid from tooth_stb on
//   gap_stb      out  1       pulse coincident with tooth_stb when that edge ends a gap
//   tooth_cnt    out  CNT_W   edge index since the last gap edge; the gap edge is 0
//   sync         out  1       wheel synchronised
//   sync_err     out  1       one-cycle pulse when sync is lost through a pattern error
//   stall        out  1       period counter saturated (engine stopped)
// BEHAVIOUR
//   Reset values: all outputs 0. Period counter = 1, FSM = IDLE.
//   Reset is valid at any cycle. A reset mid-revolution discards all state, and sync must be re-acquired.
//   Input conditioning:
//     - vr_in passes a 2-FF synchroniser.
//     - vr_filt toggles only after the synchronised level differs from vr_filt for filt_len consecutive cycles.
//     - The run counter clears whenever the two levels agree.
//   Edge detection:
//     - Active edge = vr_filt 0->1, i.e. vr_filt registered 1 while its previous value was 0.
//     - tooth_stb is asserted exactly 1 cycle after vr_filt rises.
//     - tooth_period, tooth_cnt, gap_stb and sync are updated in that same cycle.
//   Period counter pcnt:
//     - On an edge: tooth_period <= pcnt, then pcnt <= 1.
//     - Otherwise pcnt increments, saturating at 2^PCNT_W-1.
//     - Edges N cycles apart therefore give tooth_period = N.
//     - While saturated, stall = 1. The next edge clears stall.
//   Gap test:
//     - Rule: edge is a gap edge when 2*period > 3*prev_period.
//     - Evaluated at PCNT_W+2 bits; no truncation.
//     - prev_period = tooth_period before the update.
//   FSM states and transitions:
//     IDLE  first edge -> FIRST. No period is captured and tooth_stb is not asserted.
//     FIRST next edge captures the first period -> SEEK. tooth_stb is asserted; the gap test is not applied.
//     SEEK  gap edge -> SYNC: sync = 1, tooth_cnt = 0, gap_stb = 1.
//           Non-gap edge: tooth_cnt is not advanced.
//     SYNC  non-gap edge: tooth_cnt++.
//           Gap edge with tooth_cnt == TEETH-MISSING-1: tooth_cnt = 0, gap_stb = 1.
//           Gap edge with any other tooth_cnt, or a non-gap edge when tooth_cnt == TEETH-MISSING-1:
//           sync = 0, sync_err pulse, -> SEEK. tooth_cnt = 0; the edge is not counted as a gap.
//     ANY   pcnt saturates -> IDLE. sync = 0 with no sync_err pulse; tooth_period is held.
//   Simultaneous events: when saturation and an edge occur in the same cycle, the edge wins.
//     tooth_period = max, and the FSM stays in or returns to IDLE handling.
// CONFIGURATION
//   HWAG_VR_EDGE_SEL_EN
//     - Defined: adds input port edge_sel (1 bit) after filt_len.
//       edge_sel = 0 selects the rising active edge; 1 selects the falling active edge.
//       edge_sel is sampled every cycle.
//       On any change of edge_sel, the FSM goes to IDLE and pcnt = 1.
//     - Not defined: the port is absent and only the rising edge is active.
// STRUCTURE
//   hwag_pkg holds:
//     - typedef enum logic [1:0] {IDLE, FIRST, SEEK, SYNC} vr_state_t
//     - default widths PCNT_W, FILT_W, CNT_W
//   Sub-module hwag_vr_filter contains the synchroniser, filter run counter and edge detector.
//     Outputs: vr_filt, edge.
//   The top level holds the period counter, the gap comparator and the FSM.
// TESTING (clk period 20 us; TEETH=60, MISSING=2)
//   1 Filter: filt_len=3, 2-cycle vr_in glitch -> vr_filt stays 0.
//     A 10-cycle high -> vr_filt rises 2+3 cycles after vr_in.
//   2 Period: edges every 20 cycles, filt_len=1 -> tooth_period=20 from the 2nd strobe on.
//     The first edge produces no strobe.
//   3 Sync: 58 teeth at 20 cycles plus a 60-cycle gap, repeated -> gap_stb and sync=1 on the gap edge.
//     tooth_cnt runs 0..57, and the next gap edge gives tooth_cnt=0 with no sync_err.
//   4 Error: while in SYNC, inject a gap at tooth_cnt=30 -> sync_err 1 cycle, sync=0.
//     The next correct gap edge restores sync.
//   5 Stall: with PCNT_W=8, hold vr_in for 300 cycles -> stall=1 and sync=0 with no sync_err.
//     The next edge gives tooth_period=255.
//   6 Reset: assert rst for 1 cycle at tooth_cnt=40 -> all outputs 0 next cycle.
//     Re-sync is obtained only after a gap edge.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and default widths for the hwag crank VR capture front end.
`timescale 1us/1ns
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SEEK  = 2'd2,
    SYNC  = 2'd3
  } vr_state_t;

  localparam int HWAG_PCNT_W  = 24;
  localparam int HWAG_FILT_W  = 16;
  localparam int HWAG_CNT_W   = 6;
  localparam int HWAG_TEETH   = 60;
  localparam int HWAG_MISSING = 2;

endpackage

// File: rtl/hwag_vr_filter.sv
// VR input conditioning: 2-FF synchroniser, run-length glitch filter and
// active-edge detector (edge_fall selects the falling edge as active).
`timescale 1us/1ns
module hwag_vr_filter
  import hwag_pkg::*;
#(
  parameter int FILT_W = HWAG_FILT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vr_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              edge_fall,
  output logic              vr_filt,
  output logic              vr_edge
);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              vr_filt_q, vr_filt_d;
  logic              vr_prev_q, vr_prev_d;
  logic [FILT_W-1:0] run_cnt_q, run_cnt_d;
  logic [FILT_W-1:0] eff_len;
  logic [FILT_W:0]   run_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sync1_d   = vr_in;
    sync2_d   = sync1_q;
    vr_prev_d = vr_filt_q;
    vr_filt_d = vr_filt_q;
    run_cnt_d = '0;
    eff_len   = (filt_len == '0) ? FILT_W'(1) : filt_len;
    run_next  = {1'b0, run_cnt_q} + (FILT_W + 1)'(1);
    // The level flips only once it has disagreed for eff_len consecutive cycles.
    if (sync2_q != vr_filt_q) begin
      if (run_next >= {1'b0, eff_len}) begin
        vr_filt_d = ~vr_filt_q;
      end else begin
        run_cnt_d = run_next[FILT_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      vr_filt_q <= 1'b0;
      vr_prev_q <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      vr_filt_q <= vr_filt_d;
      vr_prev_q <= vr_prev_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign vr_filt = vr_filt_q;
  assign vr_edge = edge_fall ? (~vr_filt_q &  vr_prev_q)
                             : ( vr_filt_q & ~vr_prev_q);

endmodule

// File: rtl/hwag_vr_capture.sv
// Crank VR capture: tooth period counter, missing-tooth gap detection and sync FSM.
// Optional macro HWAG_VR_EDGE_SEL_EN adds the edge_sel port (falling-edge select).
`timescale 1us/1ns
module hwag_vr_capture
  import hwag_pkg::*;
#(
  parameter int PCNT_W  = HWAG_PCNT_W,
  parameter int FILT_W  = HWAG_FILT_W,
  parameter int TEETH   = HWAG_TEETH,
  parameter int MISSING = HWAG_MISSING,
  parameter int CNT_W   = HWAG_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vr_in,
  input  logic [FILT_W-1:0] filt_len,
`ifdef HWAG_VR_EDGE_SEL_EN
  input  logic              edge_sel,
`endif
  output logic              vr_filt,
  output logic              tooth_stb,
  output logic [PCNT_W-1:0] tooth_period,
  output logic              gap_stb,
  output logic [CNT_W-1:0]  tooth_cnt,
  output logic              sync,
  output logic              sync_err,
  output logic              stall
);

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TEETH - MISSING - 1);

  logic edge_sel_q;
  logic sel_chg;

`ifdef HWAG_VR_EDGE_SEL_EN
  always_ff @(posedge clk) begin
    if (rst) edge_sel_q <= 1'b0;
    else     edge_sel_q <= edge_sel;
  end
  assign sel_chg = edge_sel ^ edge_sel_q;
`else
  assign edge_sel_q = 1'b0;
  assign sel_chg    = 1'b0;
`endif

  logic vr_edge;

  hwag_vr_filter #(.FILT_W(FILT_W)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .vr_in     (vr_in),
    .filt_len  (filt_len),
    .edge_fall (edge_sel_q),
    .vr_filt   (vr_filt),
    .vr_edge   (vr_edge)
  );

  vr_state_t         state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [PCNT_W-1:0] tooth_period_q, tooth_period_d;
  logic [CNT_W-1:0]  tooth_cnt_q, tooth_cnt_d;
  logic              tooth_stb_q, tooth_stb_d;
  logic              gap_stb_q, gap_stb_d;
  logic              sync_q, sync_d;
  logic              sync_err_q, sync_err_d;
  logic              stall_q, stall_d;

  logic              sat;
  logic              is_gap;
  logic [PCNT_W+1:0] two_period;
  logic [PCNT_W+1:0] three_prev;

  // Gap rule 2*period > 3*prev, widened by two bits so neither side can overflow.
  assign two_period = {1'b0, pcnt_q, 1'b0};
  assign three_prev = {2'b00, tooth_period_q} + {1'b0, tooth_period_q, 1'b0};
  assign is_gap     = two_period > three_prev;
  assign sat        = (pcnt_q == PCNT_MAX);

  always_comb begin
    state_d        = state_q;
    pcnt_d         = sat ? pcnt_q : pcnt_q + PCNT_W'(1);
    tooth_period_d = tooth_period_q;
    tooth_cnt_d    = tooth_cnt_q;
    tooth_stb_d    = 1'b0;
    gap_stb_d      = 1'b0;
    sync_d         = sync_q;
    sync_err_d     = 1'b0;
    stall_d        = sat & ~vr_edge;

    if (sel_chg) begin
      state_d     = IDLE;
      pcnt_d      = PCNT_W'(1);
      sync_d      = 1'b0;
      tooth_cnt_d = '0;
      stall_d     = 1'b0;
    end else if (vr_edge) begin
      pcnt_d = PCNT_W'(1);
      if (sat) begin
        // Edge beats saturation: keep the maxed period but restart acquisition.
        tooth_period_d = pcnt_q;
        state_d        = FIRST;
        sync_d         = 1'b0;
        tooth_cnt_d    = '0;
      end else begin
        unique case (state_q)
          IDLE: state_d = FIRST;
          FIRST: begin
            tooth_period_d = pcnt_q;
            tooth_stb_d    = 1'b1;
            state_d        = SEEK;
          end
          SEEK: begin
            tooth_period_d = pcnt_q;
            tooth_stb_d    = 1'b1;
            if (is_gap) begin
              state_d     = SYNC;
              sync_d      = 1'b1;
              tooth_cnt_d = '0;
              gap_stb_d   = 1'b1;
            end
          end
          SYNC: begin
            tooth_period_d = pcnt_q;
            tooth_stb_d    = 1'b1;
            if (is_gap && tooth_cnt_q == LAST_CNT) begin
              tooth_cnt_d = '0;
              gap_stb_d   = 1'b1;
            end else if (!is_gap && tooth_cnt_q != LAST_CNT) begin
              tooth_cnt_d = tooth_cnt_q + CNT_W'(1);
            end else begin
              state_d     = SEEK;
              sync_d      = 1'b0;
              sync_err_d  = 1'b1;
              tooth_cnt_d = '0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (sat) begin
      state_d     = IDLE;
      sync_d      = 1'b0;
      tooth_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pcnt_q         <= PCNT_W'(1);
      tooth_period_q <= '0;
      tooth_cnt_q    <= '0;
      tooth_stb_q    <= 1'b0;
      gap_stb_q      <= 1'b0;
      sync_q         <= 1'b0;
      sync_err_q     <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      tooth_period_q <= tooth_period_d;
      tooth_cnt_q    <= tooth_cnt_d;
      tooth_stb_q    <= tooth_stb_d;
      gap_stb_q      <= gap_stb_d;
      sync_q         <= sync_d;
      sync_err_q     <= sync_err_d;
      stall_q        <= stall_d;
    end
  end

  assign tooth_stb    = tooth_stb_q;
  assign tooth_period = tooth_period_q;
  assign gap_stb      = gap_stb_q;
  assign tooth_cnt    = tooth_cnt_q;
  assign sync         = sync_q;
  assign sync_err     = sync_err_q;
  assign stall        = stall_q;

endmodule
